// File: rtl/multicycle_control.sv
// Multicycle datapath controller. This is a Moore-style FSM that sequences
// fetch, decode, execute, memory and writeback. It also has a memory-access
// timeout and a retired-instruction counter.
module multicycle_control #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [1:0]       instructionType,
  input  logic [4:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             IorD,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_type,
  output logic [4:0]       alu_opcode,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  localparam int TO_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  localparam logic [1:0] TY_R = 2'b00;
  localparam logic [1:0] TY_J = 2'b01;
  localparam logic [1:0] TY_I = 2'b10;
  localparam logic [1:0] TY_S = 2'b11;

  localparam logic [1:0] ALU_TY_I  = 2'b10;
  localparam logic [4:0] ALU_ADD   = 5'b00001;
  localparam logic [4:0] ALU_BEQ   = 5'b00100;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_WB_ALU = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_WB_LD  = 4'd7,
    S_MEM_WR = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_FAULT  = 4'd11
  } state_t;

  state_t          cur;
  state_t          nxt;
  logic [TO_W-1:0] tcnt;
  logic            mem_wait;
  logic            timeout;
  logic            retire;

  // Map an IR type/opcode pair to the state that follows DECODE.
  // Undefined encodings map to FAULT.
  function automatic state_t decode_target(input logic [1:0] ty, input logic [4:0] op);
    state_t t;
    t = S_FAULT;
    case (ty)
      TY_R, TY_S: if (op <= 5'd3) t = S_EXEC;
      TY_I: begin
        if (op <= 5'd1)                     t = S_EXEC;
        else if (op == 5'd2 || op == 5'd3)  t = S_ADDR;
        else if (op == 5'd4)                t = S_BRANCH;
      end
      TY_J: if (op == 5'd0) t = S_JUMP;
      default: t = S_FAULT;
    endcase
    return t;
  endfunction

  // The memory-waiting states stall while mem_ready is low. An access that
  // still has no mem_ready at the limit cycle times out. A mem_ready in that
  // same cycle wins and the access completes normally.
  assign mem_wait = ((cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR)) && !mem_ready;
  assign timeout  = mem_wait && (tcnt == TO_LIMIT);
  assign retire   = (cur == S_WB_ALU) || (cur == S_WB_LD) || (cur == S_BRANCH) ||
                    (cur == S_JUMP) || ((cur == S_MEM_WR) && mem_ready);
  assign state    = cur;

  // State register. Reset aborts any instruction that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  // Timeout counter. It clears on every state change, and so on entry to each
  // waiting state. It counts up only while the current access is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          tcnt <= '0;
    else if (nxt != cur) tcnt <= '0;
    else if (mem_wait)   tcnt <= tcnt + TO_W'(1);
  end

  // Retired-instruction counter. It bumps as each instruction completes and
  // wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  // Next-state logic. run is honoured only in FETCH, and only before the
  // access has started.
  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   if (run) nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready)                 nxt = S_DECODE;
        else if (!run && tcnt == '0)   nxt = S_IDLE;
        else if (timeout)              nxt = S_FAULT;
      end
      S_DECODE: nxt = decode_target(instructionType, opcode);
      S_EXEC:   nxt = S_WB_ALU;
      S_WB_ALU: nxt = S_FETCH;
      S_ADDR:   nxt = (opcode == 5'd2) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)    nxt = S_WB_LD;
        else if (timeout) nxt = S_FAULT;
      end
      S_WB_LD:  nxt = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)    nxt = S_FETCH;
        else if (timeout) nxt = S_FAULT;
      end
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_FAULT:  nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Output decode from the state register. Only ir_write/pc_write (gated by
  // mem_ready or zero), illegal and bus_error look at inputs.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    IorD       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_type   = 2'b00;
    alu_opcode = 5'b00000;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    bus_error  = timeout;
    case (cur)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        alu_type   = ALU_TY_I;
        alu_opcode = ALU_ADD;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b10;
        alu_type   = ALU_TY_I;
        alu_opcode = ALU_ADD;
        illegal    = (decode_target(instructionType, opcode) == S_FAULT);
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = (instructionType == TY_I) ? 2'b10 : 2'b00;
        alu_type   = instructionType;
        alu_opcode = opcode;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_type   = ALU_TY_I;
        alu_opcode = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        IorD     = 1'b1;
      end
      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        IorD      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_type   = ALU_TY_I;
        alu_opcode = ALU_BEQ;
        pc_source  = 2'b01;
        pc_write   = zero;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. It runs an instruction table
// through a scoreboard, followed by hand-written multi-cycle corner cases.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [1:0]  instructionType;
  logic [4:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_read, mem_write, IorD, ir_write, pc_write;
  logic [1:0]  pc_source, alu_src_b, alu_type;
  logic        alu_src_a, reg_write, mem_to_reg, illegal, bus_error;
  logic [4:0]  alu_opcode;
  logic [15:0] retired;
  logic [3:0]  state;

  int checks = 0;
  int failures = 0;

  multicycle_control #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instructionType(instructionType),
    .opcode(opcode), .zero(zero), .mem_ready(mem_ready), .mem_read(mem_read),
    .mem_write(mem_write), .IorD(IorD), .ir_write(ir_write), .pc_write(pc_write),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_type(alu_type), .alu_opcode(alu_opcode), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .bus_error(bus_error),
    .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ty;
    logic [4:0] op;
    logic       zero;
    int         len;
    int         ret;
    int         regw;
    int         memw;
    int         pcw;
    int         ill;
    int         m2r;
  } vec_t;

  vec_t tbl[10];
  vec_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock step; sampling point is just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Issue one instruction from FETCH with mem_ready=1 and measure it until
  // the FSM is back in FETCH.
  task automatic run_instr(input int idx, input vec_t v);
    int n = 0, regw = 0, memw = 0, pcw = 0, ill = 0, m2r = 0;
    logic [15:0] r0, d;
    vec_t e;
    r0 = retired;
    instructionType = v.ty;
    opcode = v.op;
    zero = v.zero;
    mem_ready = 1'b1;
    #1;
    sb.push_back(v);
    do begin
      n++;
      regw += int'(reg_write);
      memw += int'(mem_write);
      pcw  += int'(pc_write);
      ill  += int'(illegal);
      m2r  += int'(reg_write & mem_to_reg);
      step();
    end while (state != 4'd1 && n < 40);
    d = retired - r0;
    e = sb.pop_front();
    chk($sformatf("v%0d_len", idx), n, e.len);
    chk($sformatf("v%0d_retired", idx), int'(d), e.ret);
    chk($sformatf("v%0d_reg_write", idx), regw, e.regw);
    chk($sformatf("v%0d_mem_write", idx), memw, e.memw);
    chk($sformatf("v%0d_pc_write", idx), pcw, e.pcw);
    chk($sformatf("v%0d_illegal", idx), ill, e.ill);
    chk($sformatf("v%0d_mem_to_reg", idx), m2r, e.m2r);
  endtask

  initial begin
    int n;
    int k;
    int exp_st[5];
    logic [15:0] r0;

    //          ty     op        z    len ret regw memw pcw ill m2r
    tbl[0] = '{2'b00, 5'b00001, 1'b0, 4, 1, 1, 0, 1, 0, 0}; // R ADD
    tbl[1] = '{2'b11, 5'b00011, 1'b0, 4, 1, 1, 0, 1, 0, 0}; // S op3
    tbl[2] = '{2'b10, 5'b00000, 1'b0, 4, 1, 1, 0, 1, 0, 0}; // I ALU
    tbl[3] = '{2'b10, 5'b00010, 1'b0, 5, 1, 1, 0, 1, 0, 1}; // LW
    tbl[4] = '{2'b10, 5'b00011, 1'b0, 4, 1, 0, 1, 1, 0, 0}; // SW
    tbl[5] = '{2'b10, 5'b00100, 1'b1, 3, 1, 0, 0, 2, 0, 0}; // BEQ taken
    tbl[6] = '{2'b10, 5'b00100, 1'b0, 3, 1, 0, 0, 1, 0, 0}; // BEQ not taken
    tbl[7] = '{2'b01, 5'b00000, 1'b0, 3, 1, 0, 0, 2, 0, 0}; // J
    tbl[8] = '{2'b01, 5'b00011, 1'b0, 4, 0, 0, 0, 1, 1, 0}; // illegal J op
    tbl[9] = '{2'b00, 5'b00100, 1'b0, 4, 0, 0, 0, 1, 1, 0}; // illegal R op

    rst_n = 1'b0;
    run = 1'b0;
    instructionType = 2'b00;
    opcode = 5'b00001;
    zero = 1'b0;
    mem_ready = 1'b0;
    #12;
    chk("reset_state", int'(state), 0);
    chk("reset_retired", int'(retired), 0);
    chk("reset_strobes", int'({mem_read, mem_write, ir_write, pc_write, reg_write, illegal, bus_error}), 0);
    chk("reset_selects", int'({IorD, pc_source, alu_src_a, alu_src_b, alu_type, alu_opcode, mem_to_reg}), 0);

    // Leave reset with run=1: R ADD visits FETCH, DECODE, EXEC, WB_ALU, FETCH.
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    run = 1'b1;
    mem_ready = 1'b1;
    step();
    exp_st = '{1, 2, 3, 4, 1};
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("radd_state%0d", i), int'(state), exp_st[i]);
      if (i == 3) chk("radd_reg_write", int'(reg_write), 1);
      if (i < 4) step();
    end
    chk("radd_retired", int'(retired), 1);

    // Table-driven instruction mix.
    for (int i = 0; i < 10; i++) run_instr(i, tbl[i]);

    // LW with mem_ready held off for 3 cycles in MEM_RD.
    instructionType = 2'b10;
    opcode = 5'b00010;
    mem_ready = 1'b1;
    r0 = retired;
    n = 1;
    while (state != 4'd5 && n < 20) begin step(); n++; end
    mem_ready = 1'b0;
    step(); n++;
    k = 0;
    while (state == 4'd6 && k < 20) begin
      k++;
      if (k == 4) mem_ready = 1'b1;
      step(); n++;
    end
    chk("lw_memrd_cycles", k, 4);
    chk("lw_wb_state", int'(state), 7);
    chk("lw_mem_to_reg", int'(mem_to_reg), 1);
    chk("lw_total_cycles", n, 8);
    step();
    chk("lw_back_fetch", int'(state), 1);
    chk("lw_retired", int'(16'(retired - r0)), 1);

    // FETCH timeout: bus_error on the 16th waiting cycle, then FAULT, IDLE.
    mem_ready = 1'b0;
    instructionType = 2'b00;
    opcode = 5'b00001;
    #1;
    k = 0;
    for (int c = 1; c <= 30; c++) begin
      if (bus_error) begin k = c; break; end
      step();
    end
    chk("timeout_cycle", k, 16);
    step();
    chk("timeout_fault", int'(state), 11);
    step();
    chk("timeout_idle", int'(state), 0);
    step();
    chk("timeout_refetch", int'(state), 1);

    // mem_ready arriving in the timeout cycle completes normally.
    for (int c = 1; c <= 15; c++) step();
    mem_ready = 1'b1;
    #1;
    chk("late_ready_bus_error", int'(bus_error), 0);
    chk("late_ready_ir_write", int'(ir_write), 1);
    step();
    chk("late_ready_decode", int'(state), 2);
    step();
    step();
    step();
    chk("late_ready_fetch", int'(state), 1);

    // run=0 before an access starts returns to IDLE.
    r0 = retired;
    mem_ready = 1'b0;
    run = 1'b0;
    step();
    chk("run_low_idle", int'(state), 0);
    step();
    chk("run_low_stays_idle", int'(state), 0);
    run = 1'b1;
    mem_ready = 1'b1;
    step();
    chk("run_high_fetch", int'(state), 1);
    chk("run_low_retired", int'(16'(retired - r0)), 0);

    // Reset during MEM_WR aborts at once.
    instructionType = 2'b10;
    opcode = 5'b00011;
    n = 0;
    while (state != 4'd5 && n < 20) begin step(); n++; end
    mem_ready = 1'b0;
    step();
    chk("sw_memwr_state", int'(state), 8);
    chk("sw_mem_write", int'(mem_write), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mem_write", int'(mem_write), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_retired", int'(retired), 0);
    chk("rst_pc_reg_write", int'({pc_write, reg_write}), 0);
    step();
    chk("rst_hold_state", int'(state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
